// File: rtl/parallel_in_serial_out_if.sv
// Load handshake and serial stream bundle for the PISO transmitter.
// master: word source / stream observer; slave: the transmitter.
interface parallel_in_serial_out_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output serial_out,
    output serial_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/parallel_in_serial_out.sv
// Parallel-in serial-out transmitter, LSB first; optional even-parity trailer bit (PISO_PARITY_EN).
// Latency: bit 0 on serial_out one cycle after accept; frames chain back-to-back with no gap.
// Backpressure: load_ready only in IDLE or on the final frame bit, derived from state alone.
module parallel_in_serial_out #(
  parameter int   WIDTH      = 3,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  parallel_in_serial_out_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int              CNT_W    = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             last_bit;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  assign last_bit       = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign bus.load_ready = (state_q == IDLE) || last_bit;
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.serial_out   = out_q;
  assign bus.serial_valid = (state_q == SHIFT);
  assign bus.busy         = (state_q == SHIFT);
  assign bus.done         = last_bit;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      // Bit 0 leaves immediately; the shifter keeps only the bits still to send.
      state_d = SHIFT;
      out_d   = bus.load_data[0];
      shreg_d = bus.load_data >> 1;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^bus.load_data;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          out_d = IDLE_LEVEL;
        end
        SHIFT: begin
          if (last_bit) begin
            state_d = IDLE;
            out_d   = IDLE_LEVEL;
            shreg_d = '0;
            cnt_d   = '0;
          end else begin
            out_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
`ifdef PISO_PARITY_EN
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              out_d = par_q;
            end
`endif
          end
        end
        default: begin
          state_d = IDLE;
          out_d   = IDLE_LEVEL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_parallel_in_serial_out.sv
// Scoreboard bench for parallel_in_serial_out: driver queues expected bits, monitor checks the stream.
module tb_parallel_in_serial_out;
  localparam int W = 3;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
  localparam logic [FRAME-1:0] B110 = 4'b0110;
  localparam logic [FRAME-1:0] B101 = 4'b0101;
  localparam logic [FRAME-1:0] B011 = 4'b0011;
  localparam logic [FRAME-1:0] B111 = 4'b1111;
  localparam logic [FRAME-1:0] B010 = 4'b1010;
  localparam logic [FRAME-1:0] B001 = 4'b1001;
`else
  localparam int FRAME = W;
  localparam logic [FRAME-1:0] B110 = 3'b110;
  localparam logic [FRAME-1:0] B101 = 3'b101;
  localparam logic [FRAME-1:0] B011 = 3'b011;
  localparam logic [FRAME-1:0] B111 = 3'b111;
  localparam logic [FRAME-1:0] B010 = 3'b010;
  localparam logic [FRAME-1:0] B001 = 3'b001;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  parallel_in_serial_out_if #(.WIDTH(W)) bus ();

  parallel_in_serial_out #(
    .WIDTH(W),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         b;
    logic         d;
    int           cyc;
    logic [W-1:0] word;
    logic         is_data;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               done_cnt = 0;
  bit               mon_en = 1'b0;
  bit               accepted = 1'b0;
  logic [W-1:0]     sipo = '0;
  logic [W-1:0]     cur_word = '0;
  logic [FRAME-1:0] cur_bits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every frame bit must match the queue head, stamped for this exact cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset_n)
        chk("load_ready", 32'(bus.load_ready), 32'((!bus.serial_valid) || bus.done));
      chk("busy_vs_valid", 32'(bus.busy), 32'(bus.serial_valid));
      if (bus.serial_valid) begin
        chk("bit_expected", 32'(q.size() != 0), 32'(1));
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("bit_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("serial_out", 32'(bus.serial_out), 32'(mon_e.b));
          chk("done", 32'(bus.done), 32'(mon_e.d));
          if (mon_e.is_data) sipo = {bus.serial_out, sipo[W-1:1]};
          if (bus.done) begin
            done_cnt++;
            chk("sipo_word", 32'(sipo), 32'(mon_e.word));
          end
        end
      end else begin
        chk("idle_level", 32'(bus.serial_out), 32'(0));
        chk("idle_done", 32'(bus.done), 32'(0));
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("bit_missing_valid", 32'(bus.serial_valid), 32'(1));
          void'(q.pop_front());
        end
      end
    end
  end

  // One clock: predict the effect of the coming edge, then return just after it.
  task automatic step();
    @(negedge clk);
    if (!reset_n) begin
      while (q.size() != 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
    end else if (bus.load_valid && bus.load_ready) begin
      for (int k = 0; k < FRAME; k++)
        q.push_back('{b: cur_bits[k], d: (k == FRAME - 1), cyc: cyc + 1 + k,
                      word: cur_word, is_data: (k < W)});
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] word, input logic [FRAME-1:0] bits);
    cur_word       = word;
    cur_bits       = bits;
    bus.load_data  = word;
    bus.load_valid = 1'b1;
    accepted       = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) step();
    chk("accept_in_time", 32'(accepted), 32'(1));
    bus.load_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int d0;
    bus.load_data  = 3'b111;
    bus.load_valid = 1'b1;
    reset_n        = 1'b0;

    // 1: reset held with a word offered
    idle(2);
    chk("rst_serial_out", 32'(bus.serial_out), 32'(0));
    chk("rst_serial_valid", 32'(bus.serial_valid), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    bus.load_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rst_load_ready", 32'(bus.load_ready), 32'(1));
    mon_en = 1'b1;
    idle(2);

    // 2: single word
    d0 = done_cnt;
    send(3'b110, B110);
    idle(FRAME + 2);
    chk("single_done_pulses", 32'(done_cnt - d0), 32'(1));

    // 3: back-to-back words
    d0 = done_cnt;
    send(3'b101, B101);
    send(3'b011, B011);
    idle(FRAME + 2);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'(2));

    // 4: reset mid-frame, then a fresh word
    send(3'b111, B111);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_serial_out", 32'(bus.serial_out), 32'(0));
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_valid", 32'(bus.serial_valid), 32'(0));
    #1;
    chk("abort_load_ready", 32'(bus.load_ready), 32'(1));
    idle(1);
    send(3'b010, B010);
    idle(FRAME + 2);

    // 5: load_data wiggles while a frame is in flight with load_valid low
    send(3'b001, B001);
    bus.load_data = 3'b110;
    step();
    bus.load_data = 3'b111;
    step();
    bus.load_data = 3'b000;
    idle(FRAME + 2);

`ifdef PISO_PARITY_EN
    // 6: parity frames
    d0 = done_cnt;
    send(3'b110, 4'b0110);
    idle(FRAME + 2);
    send(3'b111, 4'b1111);
    idle(FRAME + 2);
    chk("parity_done_pulses", 32'(done_cnt - d0), 32'(2));
`endif

    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
